// File: rtl/aes_pkg.sv
// Shared AES SubBytes definitions: forward and inverse S-box tables,
// engine FSM state type and the lane-count legality check.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sbe_state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic bit legal_lanes(input int nbytes, input int lanes);
    bit pow_ok;
    pow_ok = (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
    return pow_ok && (nbytes > 0) && ((nbytes % lanes) == 0);
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte of S-box substitution; inv selects the inverse table.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       inv,
  output logic [7:0] byte_out
);

  // Table lookup, forward or inverse
  always_comb begin
    byte_out = 8'h00;
    if (inv) begin
      byte_out = INV_SBOX[byte_in];
    end else begin
      byte_out = SBOX[byte_in];
    end
  end

endmodule

// File: rtl/aes_subbytes_engine.sv
// Multi-cycle SubBytes/InvSubBytes engine: one state per handshake,
// LANES bytes substituted per beat, NBYTES/LANES beats per state.
module aes_subbytes_engine
  import aes_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                out_inv
);

  localparam int BEATS = NBYTES / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  generate
    if (!legal_lanes(NBYTES, LANES)) begin : g_bad_lanes
      $error("aes_subbytes_engine: LANES must be 1,2,4,8 or 16 and divide NBYTES");
    end
  endgenerate

  sbe_state_t                        r_state;
  sbe_state_t                        w_state_nxt;
  logic [CW-1:0]                     r_cnt;
  logic [8*NBYTES-1:0]               r_data;
  logic                              r_inv;
  logic                              w_accept;
  logic                              w_last;
  logic [BEATS-1:0][LANES-1:0][7:0]  w_view;
  logic [LANES-1:0][7:0]             w_lane_in;
  logic [LANES-1:0][7:0]             w_lane_out;
  logic [NBYTES-1:0]                 w_byte_en;

  // The state viewed as beats of LANES bytes; beat k holds bytes k*LANES upward
  assign w_view   = r_data;
  assign w_last   = (r_cnt == LAST_BEAT);
  assign w_accept = in_valid && in_ready;
  assign out_data = r_data;
  assign out_inv  = r_inv;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = BUSY;
        else          w_state_nxt = IDLE;
      end
      BUSY: begin
        if (w_last) w_state_nxt = DONE;
        else        w_state_nxt = BUSY;
      end
      DONE: begin
        if (w_accept)       w_state_nxt = BUSY;
        else if (out_ready) w_state_nxt = IDLE;
        else                w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready may follow out_ready in DONE so results can chain
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      BUSY: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Byte mux feeding the lanes from the current beat
  always_comb begin
    w_lane_in = w_view[r_cnt];
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      aes_sbox_lane u_lane (
        .byte_in  (w_lane_in[l]),
        .inv      (r_inv),
        .byte_out (w_lane_out[l])
      );
    end
  endgenerate

  // Per-byte write enable: only the bytes of the active beat are replaced
  always_comb begin
    w_byte_en = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if ((r_state == BUSY) && (r_cnt == CW'(i / LANES))) begin
        w_byte_en[i] = 1'b1;
      end else begin
        w_byte_en[i] = 1'b0;
      end
    end
  end

  // Beat counter: cleared on accept, saturates on the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == BUSY) && !w_last) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // State and mode registers; data is captured on accept and rewritten in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_inv  <= 1'b0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_inv  <= in_inv;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_byte_en[i]) r_data[8*i +: 8] <= w_lane_out[i % LANES];
      end
    end
  end

endmodule

// File: tb/tb_aes_subbytes_engine.sv
// Directed bench for aes_subbytes_engine at LANES=4, 1 and 16, checked
// against an S-box model derived from GF(2^8) inversion plus the affine map.
module tb_aes_subbytes_engine;

  localparam int ND = 3;

  logic         clk;
  logic         rst_n;
  logic         iv   [ND];
  logic         ii   [ND];
  logic         ordy [ND];
  logic [127:0] id   [ND];
  wire          ir   [ND];
  wire          ov   [ND];
  wire          oi   [ND];
  wire  [127:0] od   [ND];

  int errors = 0;
  int checks = 0;
  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];

  aes_subbytes_engine #(.NBYTES(16), .LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_inv(ii[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_inv(oi[0]));
  aes_subbytes_engine #(.NBYTES(16), .LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_inv(ii[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_inv(oi[1]));
  aes_subbytes_engine #(.NBYTES(16), .LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]), .in_inv(ii[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_inv(oi[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int beats_of(input int d);
    if (d == 0) return 4;
    else if (d == 1) return 16;
    else return 1;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_model();
    logic [7:0] inv_x, s;
    for (int x = 0; x < 256; x++) begin
      inv_x = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv_x = 8'(y);
      end
      s = inv_x ^ rotl(inv_x, 1) ^ rotl(inv_x, 2) ^ rotl(inv_x, 3) ^ rotl(inv_x, 4) ^ 8'h63;
      m_fwd[x] = s;
      m_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub_state(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = inv ? m_inv[s[8*i +: 8]] : m_fwd[s[8*i +: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] make_state(input int j);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'((j * 37 + i * 11 + 3) & 255);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction with out_ready high; lat = cycles from accept edge to out_valid, -1 on timeout
  task automatic do_txn(input int d, input logic [127:0] data, input logic inv,
                        output logic [127:0] res, output logic res_inv, output int lat);
    int guard;
    lat = -1; res = '0; res_inv = 1'b0;
    id[d] = data; ii[d] = inv; iv[d] = 1'b1; ordy[d] = 1'b1;
    guard = 0;
    while (!ir[d] && guard < 100) begin tick(); guard++; end
    if (!ir[d]) begin
      iv[d] = 1'b0;
      return;
    end
    tick();
    iv[d] = 1'b0; id[d] = {4{32'hdeadbeef}}; ii[d] = ~inv;
    guard = 0;
    while (!ov[d] && guard < 100) begin tick(); guard++; end
    if (ov[d]) begin
      lat = guard; res = od[d]; res_inv = oi[d];
    end
    tick();
    ordy[d] = 1'b0; ii[d] = 1'b0; id[d] = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      iv[d] = 1'b0; ii[d] = 1'b0; ordy[d] = 1'b0; id[d] = '0;
    end
    #2;
    for (int d = 0; d < ND; d++) begin
      checks++; if (ov[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d got=%b want=0", d, ov[d]); end
      checks++; if (od[d] !== 128'h0) begin errors++; $display("FAIL reset_out_data dut%0d got=%h want=0", d, od[d]); end
      checks++; if (oi[d] !== 1'b0) begin errors++; $display("FAIL reset_out_inv dut%0d got=%b want=0", d, oi[d]); end
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < ND; d++) begin
      checks++; if (ir[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d got=%b want=1", d, ir[d]); end
    end
  endtask

  task automatic test_basic(input int d);
    logic [127:0] res; logic rinv; int lat;
    do_txn(d, 128'h0, 1'b0, res, rinv, lat);
    checks++; if (lat != beats_of(d)) begin errors++; $display("FAIL basic_latency dut%0d got=%0d want=%0d", d, lat, beats_of(d)); end
    checks++; if (res !== {16{8'h63}}) begin errors++; $display("FAIL basic_zero_fwd dut%0d got=%h want=%h", d, res, {16{8'h63}}); end
    checks++; if (rinv !== 1'b0) begin errors++; $display("FAIL basic_out_inv dut%0d got=%b want=0", d, rinv); end
  endtask

  task automatic test_inverse();
    logic [127:0] res; logic rinv; int lat;
    do_txn(0, {16{8'h63}}, 1'b1, res, rinv, lat);
    checks++; if (res !== 128'h0) begin errors++; $display("FAIL inv_63 got=%h want=0", res); end
    checks++; if (rinv !== 1'b1) begin errors++; $display("FAIL inv_out_inv got=%b want=1", rinv); end
    do_txn(0, 128'h000000000000000000000000_e99aa019, 1'b0, res, rinv, lat);
    checks++;
    if (res !== 128'h636363636363636363636363_1eb8e0d4) begin
      errors++; $display("FAIL fips_column got=%h want=636363636363636363636363_1eb8e0d4", res);
    end
  endtask

  task automatic test_exhaustive();
    logic [127:0] st, res, back; logic rinv; int lat;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) st[8*i +: 8] = 8'(k * 16 + i);
      do_txn(0, st, 1'b0, res, rinv, lat);
      checks++; if (res !== sub_state(st, 1'b0)) begin errors++; $display("FAIL exh_fwd blk%0d got=%h want=%h", k, res, sub_state(st, 1'b0)); end
      do_txn(0, res, 1'b1, back, rinv, lat);
      checks++; if (back !== st) begin errors++; $display("FAIL exh_roundtrip blk%0d got=%h want=%h", k, back, st); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b;
    int guard;
    a = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    b = 128'h00112233445566778899aabbccddeeff;
    id[0] = a; ii[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
    tick();
    id[0] = b;
    guard = 0;
    while (!ov[0] && guard < 100) begin tick(); guard++; end
    checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_first_valid got=%b want=1", ov[0]); end
    for (int c = 0; c < 10; c++) begin
      checks++; if (od[0] !== sub_state(a, 1'b0)) begin errors++; $display("FAIL bp_hold_data cyc%0d got=%h want=%h", c, od[0], sub_state(a, 1'b0)); end
      checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got=%b want=0", c, ir[0]); end
      checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc%0d got=%b want=1", c, ov[0]); end
      tick();
    end
    ordy[0] = 1'b1;
    #1;
    checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b want=1", ir[0]); end
    tick();
    iv[0] = 1'b0; ordy[0] = 1'b0;
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL bp_second_busy got=%b want=0", ov[0]); end
    guard = 0;
    while (!ov[0] && guard < 100) begin tick(); guard++; end
    checks++; if (od[0] !== sub_state(b, 1'b0)) begin errors++; $display("FAIL bp_second_data got=%h want=%h", od[0], sub_state(b, 1'b0)); end
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
  endtask

  task automatic test_back_to_back(input int d);
    int nin, nout, last_t, cyc, bts;
    logic acc;
    bts = beats_of(d);
    nin = 0; nout = 0; last_t = -1; cyc = 0;
    id[d] = make_state(0); ii[d] = 1'b0; iv[d] = 1'b1; ordy[d] = 1'b1;
    while (nout < 8 && cyc < 8 * (bts + 1) + 40) begin
      if (ov[d]) begin
        checks++;
        if (od[d] !== sub_state(make_state(nout), 1'b0)) begin
          errors++; $display("FAIL b2b_data dut%0d res%0d got=%h want=%h", d, nout, od[d], sub_state(make_state(nout), 1'b0));
        end
        if (nout > 0) begin
          checks++;
          if (cyc - last_t != bts + 1) begin
            errors++; $display("FAIL b2b_period dut%0d res%0d got=%0d want=%0d", d, nout, cyc - last_t, bts + 1);
          end
        end
        last_t = cyc;
        nout++;
      end
      acc = iv[d] && ir[d];
      tick();
      cyc++;
      if (acc) begin
        nin++;
        if (nin < 8) id[d] = make_state(nin);
        else iv[d] = 1'b0;
      end
    end
    checks++; if (nout != 8) begin errors++; $display("FAIL b2b_count dut%0d got=%0d want=8", d, nout); end
    iv[d] = 1'b0; ordy[d] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [127:0] res; logic rinv; int lat;
    id[0] = 128'h0123456789abcdef0123456789abcdef; ii[0] = 1'b1; iv[0] = 1'b1; ordy[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b want=0", ov[0]); end
    checks++; if (od[0] !== 128'h0) begin errors++; $display("FAIL mid_reset_data got=%h want=0", od[0]); end
    checks++; if (oi[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_inv got=%b want=0", oi[0]); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%b want=1", ir[0]); end
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_idle got=%b want=0", ov[0]); end
    do_txn(0, 128'h000000000000000000000000_e99aa019, 1'b0, res, rinv, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL mid_reset_latency got=%0d want=4", lat); end
    checks++;
    if (res !== 128'h636363636363636363636363_1eb8e0d4) begin
      errors++; $display("FAIL mid_reset_next got=%h want=636363636363636363636363_1eb8e0d4", res);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    for (int d = 0; d < ND; d++) test_basic(d);
    test_inverse();
    test_exhaustive();
    test_backpressure();
    for (int d = 0; d < ND; d++) test_back_to_back(d);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
